alu_operand_stage: RTL
======================

# alu_operand_stage

Operand-issue stage directly upstream of the ALU operation units (AND/OR/ADD/etc.). It holds the 32 x 32-bit integer register file and reads two source registers with same-cycle writeback bypass. It selects register or immediate for operand B and latches the operands plus ALU opcode into a valid/ready pipeline register. The ALU's 32-bit A/B inputs are driven straight from this register.

## Interface
Parameters:
- XLEN, 32, operand and register width
- NREG, 32, register count; address width is log2(NREG) = 5
- OPW, 4, ALU opcode width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  issue request valid
- in_ready  out  1  stage can accept this cycle
- rs1_addr  in  5  source register for operand A
- rs2_addr  in  5  source register for operand B
- imm  in  XLEN  immediate value
- use_imm  in  1  1: operand B = imm; 0: operand B = reg[rs2_addr]
- alu_op  in  OPW  opcode passed through to the ALU
- wb_en  in  1  register write enable from writeback
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data
- flush  in  1  discard the held operation and block acceptance
- out_valid  out  1  op_a/op_b/out_alu_op are valid
- out_ready  in  1  ALU consumes this cycle
- op_a  out  XLEN  ALU input A
- op_b  out  XLEN  ALU input B
- out_alu_op  out  OPW  registered opcode

## Operation
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs at the clk edge when wb_en=1, including during flush and stall cycles.
- Read bypass: when wb_en=1, wb_addr==rsN_addr and rsN_addr!=0, the read value is wb_data, not the stored value.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and has no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, the pipeline register is loaded:
  - op_a = bypassed reg[rs1_addr]
  - op_b = use_imm ? imm : bypassed reg[rs2_addr]
  - out_alu_op = alu_op
  - rs1_addr, rs2_addr and use_imm are captured internally.
  - out_valid <= 1
- Consume without new accept (out_valid && out_ready && !accept): out_valid <= 0. Data registers hold their last value.
- Stall refresh: while out_valid=1 and the entry is not consumed, a writeback whose wb_addr matches a captured source address (nonzero) overwrites the held value at that edge:
  - op_a is updated on a match with captured rs1.
  - op_b is updated on a match with captured rs2, and only when captured use_imm=0.
- Flush: out_valid <= 0 at the next edge. No accept occurs that cycle. Flush overrides a simultaneous out_ready; the ALU must not treat that cycle as a consume.
- Reset:
  - All registers, op_a, op_b and out_alu_op are set to 0; out_valid is set to 0.
  - in_ready reads 1 the cycle after reset deasserts.
  - Inputs and wb_en are ignored in a reset cycle.
  - Reset mid-stall drops the held entry.

## Timing
- Latency: 1 cycle. An accept at edge N gives out_valid=1 with the data visible after edge N.
- Throughput: 1 op/cycle while out_ready=1 (back-to-back accepts).
- Writeback at the same edge as an accept is captured through the bypass. The register file and the pipeline register both receive wb_data at that edge.
- Writeback at the same edge as a consume-plus-accept: the new entry uses the bypass, and the old entry is not refreshed.
- Outputs are registered. in_ready is the only combinational output, dependent on flush, out_valid and out_ready.

## Test plan
- Reset, then write x5=0x0000_00FF, x6=0xF0F0_0000. Issue rs1=5, rs2=6, use_imm=0, alu_op=OR -> next cycle op_a=0x0000_00FF, op_b=0xF0F0_0000, out_valid=1.
- Bypass: wb_en with x7=0x1234_5678 in the same cycle as issuing rs1=7 -> op_a=0x1234_5678. A later read of x7 also returns 0x1234_5678.
- x0: write x0=0xFFFF_FFFF, then issue rs1=0, use_imm=1, imm=0xABC -> op_a=0, op_b=0x0000_0ABC.
- Stall refresh: hold out_ready=0 with an entry using rs2=9 (use_imm=0), then write x9=0xDEAD_BEEF -> op_b becomes 0xDEAD_BEEF next cycle. The same test with use_imm=1 leaves op_b unchanged.
- Backpressure/flush: with out_valid=1 and out_ready=0, in_ready=0 and a new in_valid is not accepted. Assert flush -> out_valid=0 next cycle, in_ready=0 during the flush cycle.
- Streaming: 8 consecutive issues with out_ready=1 -> 8 outputs on consecutive cycles in order. Reset asserted mid-stream -> out_valid=0 and all registers read 0 afterwards.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand-issue stage feeding the ALU: integer register file with writeback bypass,
// register/immediate mux for operand B, and a valid/ready register holding the issued operands.
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int OPW  = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   input  logic [OPW-1:0]  alu_op,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic [OPW-1:0]  out_alu_op
);

   logic [XLEN-1:0] rf [NREG];

   logic [AW-1:0]   cap_rs1;
   logic [AW-1:0]   cap_rs2;
   logic            cap_use_imm;

   logic            wb_live;
   logic            accept;
   logic            consume;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            refresh_a;
   logic            refresh_b;

   // Writes to x0 are dropped here so x0 never needs a read-side special case beyond the bypass.
   assign wb_live = wb_en && (wb_addr != '0);

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   // A flush cycle is never a consume even if the ALU raises out_ready.
   assign consume  = out_valid && out_ready && !flush;

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1_addr != '0) begin
         rd1 = (wb_live && (wb_addr == rs1_addr)) ? wb_data : rf[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rd2 = (wb_live && (wb_addr == rs2_addr)) ? wb_data : rf[rs2_addr];
      end
   end

   // A held entry tracks writebacks to its sources so it never issues stale operands.
   assign refresh_a = wb_live && (wb_addr == cap_rs1);
   assign refresh_b = wb_live && (wb_addr == cap_rs2) && !cap_use_imm;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (wb_live) begin
         rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         out_alu_op  <= '0;
         cap_rs1     <= '0;
         cap_rs2     <= '0;
         cap_use_imm <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         op_a        <= rd1;
         op_b        <= use_imm ? imm : rd2;
         out_alu_op  <= alu_op;
         cap_rs1     <= rs1_addr;
         cap_rs2     <= rs2_addr;
         cap_use_imm <= use_imm;
      end else if (consume) begin
         out_valid <= 1'b0;
      end else if (out_valid) begin
         if (refresh_a) begin
            op_a <= wb_data;
         end
         if (refresh_b) begin
            op_b <= wb_data;
         end
      end
   end

endmodule
